control_unit: RTL
=================

CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 Clock  input  1  system clock; all state changes on the rising edge.
REQ-002 Clear  input  1  reset, asynchronous, active-low.
REQ-003 IR  input  32  instruction register contents; opcode is IR[31:27].
REQ-004 CON_FF  input  1  branch condition flag from the datapath.
REQ-005 Stop  input  1  halt request, sampled at each instruction boundary.
REQ-006 Mem_rdy  input  1  memory completion strobe; used only under MEM_WAIT_EN.
REQ-007 PCout, Zhiout, Zlowout, MDRout, HIout, LOout, InPortout, Cout  output  1 each  bus-drive selects.
REQ-008 PCin, IRin, MARin, MDRin, Yin, Zin, HIin, LOin, OutPortin  output  1 each  register load enables.
REQ-009 IncPC, Read, Write, CONin  output  1 each  PC increment, memory strobes, condition-flag load.
REQ-010 Gra, Grb, Grc, Rin, Rout, BAout  output  1 each  register-file select and control.
REQ-011 ALUop  output  4  ALU operation select.
REQ-012 Run  output  1  high while executing; low in HALT.

Function
REQ-013 The control unit SHALL be a Moore FSM with outputs decoded from the current state only, one state per clock.
REQ-014 States SHALL be RST, T0..T7 and HALT; in each state, any output not listed is 0.
REQ-015 Fetch SHALL be: T0 asserts PCout, MARin, IncPC, Zin; T1 asserts Zlowout, PCin, Read, MDRin; T2 asserts MDRout, IRin.
REQ-016 In T3, the opcode SHALL be decoded from IR[31:27], which is sampled in T3 only.
REQ-017 ld SHALL be: T3 Grb, BAout, Yin; T4 Cout, ALUop=ADD, Zin; T5 Zlowout, MARin; T6 Read, MDRin; T7 MDRout, Gra, Rin; then T0.
REQ-018 ldi SHALL use ld's T3 and T4, then T5 Zlowout, Gra, Rin; then T0.
REQ-019 st SHALL use ld's T3..T5, then T6 Gra, Rout, MDRin; T7 Write; then T0.
REQ-020 add/sub/and/or SHALL be: T3 Grb, Rout, Yin; T4 Grc, Rout, ALUop=op, Zin; T5 Zlowout, Gra, Rin; then T0.
REQ-021 br SHALL be: T3 Gra, Rout, CONin; T4 PCout, Yin; T5 Cout, ALUop=ADD, Zin; T6 Zlowout, with PCin=CON_FF; then T0.
REQ-022 jr SHALL be: T3 Gra, Rout, PCin; then T0.
REQ-023 nop and undefined opcodes SHALL return from T3 to T0 with no outputs asserted.
REQ-024 halt SHALL go from T3 to HALT; HALT is absorbing, and only Clear exits it.
REQ-025 With Stop=1 at the last state of an instruction, the next state SHALL be HALT instead of T0.
REQ-026 Run SHALL be 1 in every state except RST and HALT.
REQ-027 When idle, ALUop SHALL be 0000 (ADD).

Reset
REQ-028 Clear low SHALL force state RST and all outputs to 0 immediately, including mid-instruction and mid-memory-wait.
REQ-029 After Clear goes high, RST SHALL advance to T0 on the next rising edge.

Configuration
REQ-030 With MEM_WAIT_EN defined, any state asserting Read or Write SHALL hold, with outputs held, until a rising edge where Mem_rdy=1.
REQ-031 Without MEM_WAIT_EN, Read and Write states SHALL last exactly one cycle and Mem_rdy SHALL be ignored.

Structure
REQ-032 Package cpu_pkg SHALL hold the opcode constants: ld=00000, ldi=00001, st=00010, add=00011, sub=00100, and=00101, or=00110, br=10010, jr=10100, nop=11010, halt=11011.
REQ-033 cpu_pkg SHALL also hold the ALUop constants (ADD=0000, SUB=0001, AND=0010, OR=0011) and the state encoding.
REQ-034 One sub-module, op_decoder, SHALL map the opcode to an instruction class and ALUop combinationally.

Verification
REQ-035 After Clear release, ld with IR=0x00800055 SHALL produce T0..T7 in 8 cycles with REQ-017 strobes and Run=1, then return to T0.
REQ-036 add SHALL assert Grc, Rout and Zin with ALUop=0000 in T4, and Gra and Rin in T5, then return to T0 after 6 cycles total.
REQ-037 br with CON_FF=0 SHALL hold PCin=0 in T6; with CON_FF=1, PCin SHALL be 1 in T6.
REQ-038 Under MEM_WAIT_EN, holding Mem_rdy=0 for 3 cycles in T1 SHALL keep Read=1 for 4 cycles before T2.
REQ-039 Clear low during T5 of st SHALL zero all outputs asynchronously, and restart at T0 after release.
REQ-040 halt, or Stop=1 at T7 of ld, SHALL enter HALT with Run=0 held for 20 cycles.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the control unit: opcodes, ALU operation codes,
// FSM state encoding, instruction classes and the control-strobe bundle.
package cpu_pkg;

  // Opcodes carried in IR[31:27]
  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_BR   = 5'b10010;
  localparam logic [4:0] OP_JR   = 5'b10100;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  // ALU operation select codes
  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_AND = 4'b0010;
  localparam logic [3:0] ALU_OR  = 4'b0011;

  // Control FSM states
  typedef enum logic [3:0] {
    ST_RST  = 4'd0,
    ST_T0   = 4'd1,
    ST_T1   = 4'd2,
    ST_T2   = 4'd3,
    ST_T3   = 4'd4,
    ST_T4   = 4'd5,
    ST_T5   = 4'd6,
    ST_T6   = 4'd7,
    ST_T7   = 4'd8,
    ST_HALT = 4'd9
  } state_e;

  // Instruction classes; nop and undefined opcodes share CL_NOP
  typedef enum logic [2:0] {
    CL_NOP  = 3'd0,
    CL_LD   = 3'd1,
    CL_LDI  = 3'd2,
    CL_ST   = 3'd3,
    CL_ALU  = 3'd4,
    CL_BR   = 3'd5,
    CL_JR   = 3'd6,
    CL_HALT = 3'd7
  } iclass_e;

  // All control strobes driven by the unit
  typedef struct packed {
    logic       pc_out;
    logic       zhi_out;
    logic       zlow_out;
    logic       mdr_out;
    logic       hi_out;
    logic       lo_out;
    logic       inport_out;
    logic       c_out;
    logic       pc_in;
    logic       ir_in;
    logic       mar_in;
    logic       mdr_in;
    logic       y_in;
    logic       z_in;
    logic       hi_in;
    logic       lo_in;
    logic       outport_in;
    logic       inc_pc;
    logic       read;
    logic       write;
    logic       con_in;
    logic       gra;
    logic       grb;
    logic       grc;
    logic       r_in;
    logic       r_out;
    logic       ba_out;
    logic [3:0] alu_op;
    logic       run;
  } ctrl_t;

endpackage

// File: rtl/op_decoder.sv
// Combinational opcode decoder: opcode -> instruction class and ALU operation.
module op_decoder
  import cpu_pkg::*;
(
  input  logic [4:0] i_opcode,
  output iclass_e    o_class,
  output logic [3:0] o_aluop
);

  // Map each opcode to its class; non-ALU classes select ADD
  always_comb begin
    o_class = CL_NOP;
    o_aluop = ALU_ADD;
    case (i_opcode)
      OP_LD:   o_class = CL_LD;
      OP_LDI:  o_class = CL_LDI;
      OP_ST:   o_class = CL_ST;
      OP_ADD:  begin o_class = CL_ALU; o_aluop = ALU_ADD; end
      OP_SUB:  begin o_class = CL_ALU; o_aluop = ALU_SUB; end
      OP_AND:  begin o_class = CL_ALU; o_aluop = ALU_AND; end
      OP_OR:   begin o_class = CL_ALU; o_aluop = ALU_OR;  end
      OP_BR:   o_class = CL_BR;
      OP_JR:   o_class = CL_JR;
      OP_HALT: o_class = CL_HALT;
      default: begin o_class = CL_NOP; o_aluop = ALU_ADD; end
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Hardwired Moore control unit: fetch T0..T2, decode in T3, execute T4..T7.
// Optional build macro MEM_WAIT_EN: Read/Write states hold until Mem_rdy=1.
// Strobes are decoded from the current state (and the class latched in T3),
// so pulling Clear low zeroes every output without waiting for a clock.
module control_unit
  import cpu_pkg::*;
(
  input  logic        Clock,
  input  logic        Clear,
  input  logic [31:0] IR,
  input  logic        CON_FF,
  input  logic        Stop,
  input  logic        Mem_rdy,
  output logic        PCout, Zhiout, Zlowout, MDRout, HIout, LOout, InPortout, Cout,
  output logic        PCin, IRin, MARin, MDRin, Yin, Zin, HIin, LOin, OutPortin,
  output logic        IncPC, Read, Write, CONin,
  output logic        Gra, Grb, Grc, Rin, Rout, BAout,
  output logic [3:0]  ALUop,
  output logic        Run
);

  state_e     r_state, w_next, w_done;
  iclass_e    r_cls, w_cls_dec;
  logic [3:0] r_alu, w_alu_dec;
  ctrl_t      w_ctl;
  logic       w_mem_busy;
  logic       w_unused_ir;

  // Only the opcode field matters to this unit
  assign w_unused_ir = ^IR[26:0];

  op_decoder u_dec (
    .i_opcode (IR[31:27]),
    .o_class  (w_cls_dec),
    .o_aluop  (w_alu_dec)
  );

`ifdef MEM_WAIT_EN
  assign w_mem_busy = (w_ctl.read | w_ctl.write) & ~Mem_rdy;
`else
  logic w_unused_mem;
  assign w_unused_mem = Mem_rdy;
  assign w_mem_busy   = 1'b0;
`endif

  // State register; Clear forces RST asynchronously
  always_ff @(posedge Clock or negedge Clear) begin
    if (!Clear) r_state <= ST_RST;
    else        r_state <= w_next;
  end

  // Capture the decoded class and ALU op while in T3 for use in T4..T7
  always_ff @(posedge Clock or negedge Clear) begin
    if (!Clear) begin
      r_cls <= CL_NOP;
      r_alu <= ALU_ADD;
    end else if (r_state == ST_T3) begin
      r_cls <= w_cls_dec;
      r_alu <= w_alu_dec;
    end else begin
      r_cls <= r_cls;
      r_alu <= r_alu;
    end
  end

  // Next-state logic; an instruction's last state goes to HALT when Stop=1
  always_comb begin
    w_done = Stop ? ST_HALT : ST_T0;
    w_next = r_state;
    if (w_mem_busy) begin
      w_next = r_state;
    end else begin
      case (r_state)
        ST_RST: w_next = ST_T0;
        ST_T0:  w_next = ST_T1;
        ST_T1:  w_next = ST_T2;
        ST_T2:  w_next = ST_T3;
        ST_T3: begin
          case (w_cls_dec)
            CL_HALT:      w_next = ST_HALT;
            CL_NOP, CL_JR: w_next = w_done;
            default:      w_next = ST_T4;
          endcase
        end
        ST_T4:  w_next = ST_T5;
        ST_T5: begin
          case (r_cls)
            CL_LD, CL_ST, CL_BR: w_next = ST_T6;
            CL_LDI, CL_ALU:      w_next = w_done;
            default:             w_next = ST_T0;
          endcase
        end
        ST_T6: begin
          case (r_cls)
            CL_LD, CL_ST: w_next = ST_T7;
            CL_BR:        w_next = w_done;
            default:      w_next = ST_T0;
          endcase
        end
        ST_T7:   w_next = w_done;
        ST_HALT: w_next = ST_HALT;
        default: w_next = ST_RST;
      endcase
    end
  end

  // Output decode from the current state; anything not set stays 0
  always_comb begin
    w_ctl        = '0;
    w_ctl.alu_op = ALU_ADD;
    w_ctl.run    = (r_state != ST_RST) && (r_state != ST_HALT);
    case (r_state)
      ST_T0: begin w_ctl.pc_out = 1'b1; w_ctl.mar_in = 1'b1; w_ctl.inc_pc = 1'b1; w_ctl.z_in = 1'b1; end
      ST_T1: begin w_ctl.zlow_out = 1'b1; w_ctl.pc_in = 1'b1; w_ctl.read = 1'b1; w_ctl.mdr_in = 1'b1; end
      ST_T2: begin w_ctl.mdr_out = 1'b1; w_ctl.ir_in = 1'b1; end
      ST_T3: begin
        case (w_cls_dec)
          CL_LD, CL_LDI, CL_ST: begin w_ctl.grb = 1'b1; w_ctl.ba_out = 1'b1; w_ctl.y_in = 1'b1; end
          CL_ALU: begin w_ctl.grb = 1'b1; w_ctl.r_out = 1'b1; w_ctl.y_in = 1'b1; end
          CL_BR:  begin w_ctl.gra = 1'b1; w_ctl.r_out = 1'b1; w_ctl.con_in = 1'b1; end
          CL_JR:  begin w_ctl.gra = 1'b1; w_ctl.r_out = 1'b1; w_ctl.pc_in = 1'b1; end
          default: w_ctl.run = 1'b1;
        endcase
      end
      ST_T4: begin
        case (r_cls)
          CL_LD, CL_LDI, CL_ST: begin w_ctl.c_out = 1'b1; w_ctl.z_in = 1'b1; end
          CL_ALU: begin w_ctl.grc = 1'b1; w_ctl.r_out = 1'b1; w_ctl.z_in = 1'b1; w_ctl.alu_op = r_alu; end
          CL_BR:  begin w_ctl.pc_out = 1'b1; w_ctl.y_in = 1'b1; end
          default: w_ctl.run = 1'b1;
        endcase
      end
      ST_T5: begin
        case (r_cls)
          CL_LD, CL_ST:   begin w_ctl.zlow_out = 1'b1; w_ctl.mar_in = 1'b1; end
          CL_LDI, CL_ALU: begin w_ctl.zlow_out = 1'b1; w_ctl.gra = 1'b1; w_ctl.r_in = 1'b1; end
          CL_BR:          begin w_ctl.c_out = 1'b1; w_ctl.z_in = 1'b1; end
          default: w_ctl.run = 1'b1;
        endcase
      end
      ST_T6: begin
        case (r_cls)
          CL_LD: begin w_ctl.read = 1'b1; w_ctl.mdr_in = 1'b1; end
          CL_ST: begin w_ctl.gra = 1'b1; w_ctl.r_out = 1'b1; w_ctl.mdr_in = 1'b1; end
          CL_BR: begin w_ctl.zlow_out = 1'b1; w_ctl.pc_in = CON_FF; end
          default: w_ctl.run = 1'b1;
        endcase
      end
      ST_T7: begin
        case (r_cls)
          CL_LD: begin w_ctl.mdr_out = 1'b1; w_ctl.gra = 1'b1; w_ctl.r_in = 1'b1; end
          CL_ST: w_ctl.write = 1'b1;
          default: w_ctl.run = 1'b1;
        endcase
      end
      default: w_ctl.alu_op = ALU_ADD;
    endcase
  end

  assign PCout     = w_ctl.pc_out;
  assign Zhiout    = w_ctl.zhi_out;
  assign Zlowout   = w_ctl.zlow_out;
  assign MDRout    = w_ctl.mdr_out;
  assign HIout     = w_ctl.hi_out;
  assign LOout     = w_ctl.lo_out;
  assign InPortout = w_ctl.inport_out;
  assign Cout      = w_ctl.c_out;
  assign PCin      = w_ctl.pc_in;
  assign IRin      = w_ctl.ir_in;
  assign MARin     = w_ctl.mar_in;
  assign MDRin     = w_ctl.mdr_in;
  assign Yin       = w_ctl.y_in;
  assign Zin       = w_ctl.z_in;
  assign HIin      = w_ctl.hi_in;
  assign LOin      = w_ctl.lo_in;
  assign OutPortin = w_ctl.outport_in;
  assign IncPC     = w_ctl.inc_pc;
  assign Read      = w_ctl.read;
  assign Write     = w_ctl.write;
  assign CONin     = w_ctl.con_in;
  assign Gra       = w_ctl.gra;
  assign Grb       = w_ctl.grb;
  assign Grc       = w_ctl.grc;
  assign Rin       = w_ctl.r_in;
  assign Rout      = w_ctl.r_out;
  assign BAout     = w_ctl.ba_out;
  assign ALUop     = w_ctl.alu_op;
  assign Run       = w_ctl.run;

endmodule
